// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the rectangle fill accelerator.
//   Screen geometry, register offsets, CMD bit positions and FSM state codes.
//   Also provides the coordinate clamp helper.
package vga_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_AW    = 15;

    localparam logic [7:0] REG_X0     = 8'd0;
    localparam logic [7:0] REG_Y0     = 8'd1;
    localparam logic [7:0] REG_X1     = 8'd2;
    localparam logic [7:0] REG_Y1     = 8'd3;
    localparam logic [7:0] REG_COLOUR = 8'd4;
    localparam logic [7:0] REG_CMD    = 8'd5;
    localparam logic [7:0] NUM_REGS   = 8'd6;

    localparam int CMD_START   = 0;
    localparam int CMD_OUTLINE = 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction
endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: raster walk over a loaded rectangle, one pixel per enable.
//   CLK, RESET   : clock, synchronous active-high reset
//   load         : capture bounds and move to the top-left corner (xl, yl)
//   en           : advance one pixel (holds on the last pixel)
//   xl_in..yh_in : ordered, clamped bounds
//   x, y         : current pixel
//   last         : current pixel is (xh, yh)
//   on_edge      : current pixel lies on the rectangle border
module rect_scan_counter (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       load,
    input  logic       en,
    input  logic [7:0] xl_in,
    input  logic [7:0] xh_in,
    input  logic [6:0] yl_in,
    input  logic [6:0] yh_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last,
    output logic       on_edge
);
    logic [7:0] xl, xh;
    logic [6:0] yl, yh;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            xl <= '0;
            xh <= '0;
            yl <= '0;
            yh <= '0;
            x  <= '0;
            y  <= '0;
        end else if (load) begin
            xl <= xl_in;
            xh <= xh_in;
            yl <= yl_in;
            yh <= yh_in;
            x  <= xl_in;
            y  <= yl_in;
        end else if (en && !last) begin
            x <= (x == xh) ? xl : x + 8'd1;
            y <= (x == xh) ? y + 7'd1 : y;
        end
    end

    always_comb begin
        last    = (x == xh) && (y == yh);
        on_edge = (x == xl) || (x == xh) || (y == yl) || (y == yh);
    end
endmodule

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: bus-mapped rectangle fill engine feeding the frame buffer write port.
//   CLK, RESET : clock, synchronous active-high reset
//   BUS_ADDR/BUS_DATA/BUS_WE : 8-bit processor bus; window of 6 registers at BASE_ADDR
//   FB_ADDR/FB_DATA/FB_WE    : one pixel write per cycle, address {row, col}, row = 119 - y
//   BUSY                     : fill in progress
// Optional: define VGA_RECT_OUTLINE_EN to let CMD bit1 select border-only drawing.
module vga_rect_fill
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       BUS_ADDR,
    inout  wire  [7:0]       BUS_DATA,
    input  logic             BUS_WE,
    output logic [FB_AW-1:0] FB_ADDR,
    output logic             FB_DATA,
    output logic             FB_WE,
    output logic             BUSY
);
    logic [7:0] x0, y0, x1, y1, colour;
    logic [7:0] off, rd_data;
    logic       in_win, wr, rd_en, start, busy, colour_l, outline_l;
    logic [0:0] state;
    logic [7:0] xa, xb, ya, yb, xl_c, xh_c;
    logic [6:0] yl_c, yh_c;
    logic [7:0] x;
    logic [6:0] y;
    logic       last, on_edge;

    assign BUS_DATA = rd_en ? rd_data : 8'hzz;

    always_comb begin
        off    = BUS_ADDR - BASE_ADDR;
        in_win = off < NUM_REGS;
        wr     = BUS_WE && in_win;
        busy   = state == FILL;
        // BUSY gates the start, so a CMD landing on the final pixel is dropped.
        start  = wr && off == REG_CMD && BUS_DATA[CMD_START] && !busy;
        xa     = clamp(x0, 8'(SCREEN_W - 1));
        xb     = clamp(x1, 8'(SCREEN_W - 1));
        ya     = clamp(y0, 8'(SCREEN_H - 1));
        yb     = clamp(y1, 8'(SCREEN_H - 1));
        xl_c   = (xa < xb) ? xa : xb;
        xh_c   = (xa < xb) ? xb : xa;
        yl_c   = 7'((ya < yb) ? ya : yb);
        yh_c   = 7'((ya < yb) ? yb : ya);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x0     <= '0;
            y0     <= '0;
            x1     <= '0;
            y1     <= '0;
            colour <= '0;
        end else if (wr) begin
            if (off == REG_X0) x0 <= BUS_DATA;
            if (off == REG_Y0) y0 <= BUS_DATA;
            if (off == REG_X1) x1 <= BUS_DATA;
            if (off == REG_Y1) y1 <= BUS_DATA;
            if (off == REG_COLOUR) colour <= BUS_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_en   <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_en   <= !BUS_WE && in_win;
            rd_data <= (off == REG_X0) ? x0 :
                       (off == REG_Y0) ? y0 :
                       (off == REG_X1) ? x1 :
                       (off == REG_Y1) ? y1 :
                       (off == REG_COLOUR) ? colour : {7'b0, busy};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            colour_l <= 1'b0;
        end else if (start) begin
            state    <= FILL;
            colour_l <= colour[0];
        end else if (busy && last) begin
            state <= IDLE;
        end
    end

`ifdef VGA_RECT_OUTLINE_EN
    always_ff @(posedge CLK) begin
        if (RESET) outline_l <= 1'b0;
        else if (start) outline_l <= BUS_DATA[CMD_OUTLINE];
    end
`else
    assign outline_l = 1'b0;
`endif

    rect_scan_counter u_scan (
        .CLK     (CLK),
        .RESET   (RESET),
        .load    (start),
        .en      (busy),
        .xl_in   (xl_c),
        .xh_in   (xh_c),
        .yl_in   (yl_c),
        .yh_in   (yh_c),
        .x       (x),
        .y       (y),
        .last    (last),
        .on_edge (on_edge)
    );

    // Outputs follow the scan position directly so the first write shares the cycle BUSY rises.
    always_comb begin
        BUSY    = busy;
        FB_WE   = busy && (!outline_l || on_edge);
        FB_DATA = busy && colour_l;
        FB_ADDR = busy ? {7'(8'(SCREEN_H - 1) - {1'b0, y}), x} : '0;
    end
endmodule

// File: tb/tb_vga_rect_fill.sv
// tb_vga_rect_fill: randomized and directed checks of vga_rect_fill against a raster model.
module tb_vga_rect_fill;
    localparam logic [7:0] BASE = 8'hB4;
`ifdef VGA_RECT_OUTLINE_EN
    localparam bit OUTLINE = 1'b1;
`else
    localparam bit OUTLINE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [7:0]  dout = 8'h00;
    logic        we = 1'b0;
    logic        drv = 1'b0;
    wire  [7:0]  bus_data;
    logic [14:0] fb_addr;
    logic        fb_data, fb_we, busy;
    int          total = 0;
    int          bad = 0;

    assign bus_data = drv ? dout : 8'hzz;
    always #5 clk = ~clk;

    vga_rect_fill dut (
        .CLK      (clk),
        .RESET    (rst),
        .BUS_ADDR (addr),
        .BUS_DATA (bus_data),
        .BUS_WE   (we),
        .FB_ADDR  (fb_addr),
        .FB_DATA  (fb_data),
        .FB_WE    (fb_we),
        .BUSY     (busy)
    );

    function automatic int clampi(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic bus_idle();
        we = 1'b0;
        drv = 1'b0;
        addr = 8'h00;
    endtask

    task automatic bus_write(input int off, input int val);
        @(negedge clk);
        addr = BASE + 8'(off);
        dout = 8'(val);
        we = 1'b1;
        drv = 1'b1;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic bus_read(input int off, output logic [7:0] v);
        @(negedge clk);
        addr = BASE + 8'(off);
        we = 1'b0;
        drv = 1'b0;
        @(negedge clk);
        v = bus_data;
        addr = 8'h00;
    endtask

    // Program a rectangle, start it, then follow it cycle by cycle against the raster model.
    // poke_at/cmd_at inject X0=50 / CMD=1 writes at that scan cycle (-2 = on the last pixel);
    // rst_at asserts RESET at that scan cycle.
    task automatic scan(input string name, input int x0, input int y0, input int x1, input int y1,
                        input int col, input int cmd, input int poke_at, input int cmd_at, input int rst_at);
        int xl, xh, yl, yh, n, stop, err, wrs, exp_wrs, c_at;
        bit ol;
        bit ew[$];
        int ea[$];
        string msg;
        xl = clampi(x0, 159) < clampi(x1, 159) ? clampi(x0, 159) : clampi(x1, 159);
        xh = clampi(x0, 159) < clampi(x1, 159) ? clampi(x1, 159) : clampi(x0, 159);
        yl = clampi(y0, 119) < clampi(y1, 119) ? clampi(y0, 119) : clampi(y1, 119);
        yh = clampi(y0, 119) < clampi(y1, 119) ? clampi(y1, 119) : clampi(y0, 119);
        ol = OUTLINE && cmd[1];
        for (int yy = yl; yy <= yh; yy++)
            for (int xx = xl; xx <= xh; xx++) begin
                ew.push_back(!ol || xx == xl || xx == xh || yy == yl || yy == yh);
                ea.push_back(((119 - yy) << 8) | xx);
            end
        n = ew.size();
        stop = (rst_at >= 0) ? rst_at + 1 : n;
        c_at = (cmd_at == -2) ? n - 1 : cmd_at;
        exp_wrs = 0;
        for (int i = 0; i < stop; i++) if (ew[i]) exp_wrs++;
        bus_write(0, x0);
        bus_write(1, y0);
        bus_write(2, x1);
        bus_write(3, y1);
        bus_write(4, col);
        bus_write(5, cmd);
        err = 0;
        wrs = 0;
        msg = "";
        for (int i = 0; i <= stop + 1; i++) begin
            @(negedge clk);
            if (fb_we === 1'b1) wrs++;
            if (i < stop) begin
                if (busy !== 1'b1 || fb_we !== ew[i] ||
                    (ew[i] && (fb_addr !== 15'(ea[i]) || fb_data !== col[0]))) begin
                    err++;
                    if (err == 1)
                        msg = $sformatf("cycle %0d got busy=%b we=%b addr=%h data=%b, expected busy=1 we=%b addr=%h data=%b",
                                        i, busy, fb_we, fb_addr, fb_data, ew[i], 15'(ea[i]), col[0]);
                end
            end else if (busy !== 1'b0 || fb_we !== 1'b0) begin
                err++;
                if (err == 1)
                    msg = $sformatf("cycle %0d got busy=%b we=%b, expected idle", i, busy, fb_we);
            end
            rst = (i == rst_at);
            if (i == poke_at || i == c_at) begin
                addr = BASE + ((i == poke_at) ? 8'd0 : 8'd5);
                dout = (i == poke_at) ? 8'd50 : 8'd1;
                we = 1'b1;
                drv = 1'b1;
            end else bus_idle();
        end
        rst = 1'b0;
        bus_idle();
        total++;
        if (err != 0) begin
            bad++;
            $display("FAIL %s_scan: %s", name, msg);
        end
        total++;
        if (wrs !== exp_wrs) begin
            bad++;
            $display("FAIL %s_count: got %0d writes, expected %0d", name, wrs, exp_wrs);
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (fb_we !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got we=%b busy=%b, expected 0 0", fb_we, busy);
        end
        total++;
        if (fb_addr !== 15'h0 || fb_data !== 1'b0) begin
            bad++;
            $display("FAIL reset_fb: got addr=%h data=%b, expected 0 0", fb_addr, fb_data);
        end
        drv = 1'b1;
        dout = 8'hA5;
        #1;
        total++;
        if (bus_data !== 8'hA5) begin
            bad++;
            $display("FAIL reset_bus_release: got %h, expected a5", bus_data);
        end
        drv = 1'b0;
        rst = 1'b0;
        bus_read(5, v);
        total++;
        if (v !== 8'h00) begin
            bad++;
            $display("FAIL reset_read_cmd: got %h, expected 00", v);
        end
        bus_read(0, v);
        total++;
        if (v !== 8'h00) begin
            bad++;
            $display("FAIL reset_read_x0: got %h, expected 00", v);
        end
    endtask

    task automatic test_readback();
        logic [7:0] v;
        int vals[5];
        for (int i = 0; i < 4; i++) vals[i] = int'($urandom_range(0, 255));
        vals[4] = 1;
        for (int i = 0; i < 5; i++) bus_write(i, vals[i]);
        for (int i = 0; i < 5; i++) begin
            bus_read(i, v);
            total++;
            if (v !== 8'(vals[i])) begin
                bad++;
                $display("FAIL readback_%0d: got %h, expected %h", i, v, 8'(vals[i]));
            end
        end
    endtask

    task automatic test_no_start();
        int err = 0;
        bus_write(5, 8'hFE);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || fb_we !== 1'b0) err++;
        end
        total++;
        if (err != 0) begin
            bad++;
            $display("FAIL no_start: got %0d active cycles, expected 0", err);
        end
    endtask

    task automatic test_busy_protect();
        logic [7:0] v;
        scan("busy_protect", 0, 0, 159, 119, 0, 1, 100, 101, -1);
        bus_read(0, v);
        total++;
        if (v !== 8'd50) begin
            bad++;
            $display("FAIL busy_protect_x0: got %0d, expected 50", v);
        end
    endtask

    task automatic test_busy_read();
        logic [7:0] v;
        int k = 0;
        bus_write(0, 30);
        bus_write(1, 7);
        bus_write(2, 39);
        bus_write(3, 7);
        bus_write(5, 1);
        bus_read(5, v);
        total++;
        if (v !== 8'h01) begin
            bad++;
            $display("FAIL busy_read: got %h, expected 01", v);
        end
        while (busy === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_read_done: busy still %b after %0d cycles, expected 0", busy, k);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int x0 = int'($urandom_range(140, 220));
            int x1 = int'($urandom_range(140, 220));
            int y0 = int'($urandom_range(100, 140));
            int y1 = int'($urandom_range(100, 140));
            int cmd = int'(($urandom_range(0, 127) << 1) | 1);
            scan($sformatf("random%0d", k), x0, y0, x1, y1, int'($urandom_range(0, 1)), cmd, -1, -1, -1);
        end
        for (int k = 0; k < 4; k++) begin
            int x0 = int'($urandom_range(0, 159));
            int y0 = int'($urandom_range(0, 119));
            scan($sformatf("rand_small%0d", k), x0, y0, x0 + int'($urandom_range(0, 9)),
                 y0 - int'($urandom_range(0, y0 < 6 ? y0 : 6)), int'($urandom_range(0, 1)), 1, -1, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_readback();
        test_no_start();
        scan("small_fill", 10, 0, 12, 1, 1, 1, -1, -1, -1);
        scan("swap_clamp", 200, 5, 158, 5, 1, 1, -1, -1, -1);
        test_busy_protect();
        scan("reset_mid_fill", 20, 20, 29, 29, 1, 1, -1, -1, 20);
        scan("restart_single", 0, 0, 0, 0, 1, 1, -1, -1, -1);
        scan("back_to_back", 5, 5, 8, 6, 1, 1, -1, -2, -1);
        test_busy_read();
        test_random();
        scan("outline", 0, 0, 3, 3, 1, 3, -1, -1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
